gate_chain_seq_eval: RTL and testbench



---
 rtl/gate_chain_pkg.sv | 33 +++
 rtl/gate_chain_seq_eval_stage.sv | 21 ++
 rtl/gate_chain_seq_eval.sv | 140 ++++++++++++++
 tb/tb_gate_chain_seq_eval.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/gate_chain_pkg.sv
// Shared types and helpers for the sequential gate-chain evaluator.
// Optional build macro used by the top: GATE_CHAIN_CONST_B_EN.
package gate_chain_pkg;

    localparam int N_STAGES_MIN = 2;
    localparam int N_STAGES_MAX = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_XNOR = 2'd0,
        OP_XOR  = 2'd1,
        OP_NOR  = 2'd2
    } op_t;

    // Stage 0 is the A reduction and never goes through the shared stage;
    // the final stage is always the NOR, interior stages alternate XNOR/XOR.
    function automatic op_t stage_op(input int unsigned idx, input int unsigned n_stages);
        op_t op;
        if (idx >= n_stages - 1)
            op = OP_NOR;
        else if ((idx % 2) == 1)
            op = OP_XNOR;
        else
            op = OP_XOR;
        return op;
    endfunction

endpackage

// File: rtl/gate_chain_seq_eval_stage.sv
// One gate of the chain; a single instance is time-shared across all stages.
module gate_chain_stage
    import gate_chain_pkg::*;
(
    input  logic x_prev,
    input  logic b,
    input  op_t  op,
    output logic x
);

    always_comb begin
        x = 1'b0;
        case (op)
            OP_XNOR: x = ~(x_prev ^ b);
            OP_XOR:  x = x_prev ^ b;
            OP_NOR:  x = ~(x_prev | b);
            default: x = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_chain_seq_eval.sv
// Sequential gate chain: one stage per accepted B beat, start/busy/done control.
// Build macro GATE_CHAIN_CONST_B_EN: B sampled once at start, one stage per cycle.
module gate_chain_seq_eval
    import gate_chain_pkg::*;
#(
    parameter int A_W      = 2,
    parameter int N_STAGES = 16,
    parameter int CNT_W    = $clog2(N_STAGES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [A_W-1:0]      a_in,
    input  logic                b_valid,
    input  logic                b_in,
    output logic                b_ready,
    output logic                busy,
    output logic                done,
    output logic                result,
    output logic [N_STAGES-1:0] x_vec,
    output state_t              o_dbg_state
);

    // Handshake: a B beat is consumed on a rising edge where b_valid and
    // b_ready are both high; b_ready is high only in RUN and does not depend
    // on b_valid.

    state_t              r_state;
    state_t              w_state_next;
    logic [CNT_W-1:0]    r_stage;
    logic [N_STAGES-1:0] r_x_vec;
    logic                r_acc;
    logic                r_result;

    logic                w_start_acc;
    logic                w_beat;
    logic                w_last;
    logic                w_b;
    logic                w_x0;
    logic                w_x_prev;
    logic                w_x;
    logic                w_b_ready;
    logic [CNT_W-1:0]    w_prev_idx;
    op_t                 w_op;

    assign w_x0        = ~&a_in;
    assign w_start_acc = (r_state == IDLE) && start;
    assign w_prev_idx  = r_stage - 1'b1;
    assign w_x_prev    = r_x_vec[w_prev_idx];
    assign w_op        = stage_op(32'(r_stage), N_STAGES);
    assign w_last      = (r_stage == CNT_W'(N_STAGES - 1));

`ifdef GATE_CHAIN_CONST_B_EN
    logic r_b_const;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_b_const <= 1'b0;
        else if (w_start_acc)
            r_b_const <= b_in;
    end

    assign w_b    = r_b_const;
    assign w_beat = (r_state == RUN);
`else
    assign w_b    = b_in;
    assign w_beat = b_valid && w_b_ready;
`endif

    gate_chain_stage u_stage (
        .x_prev (w_x_prev),
        .b      (w_b),
        .op     (w_op),
        .x      (w_x)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = RUN;
            RUN:     if (w_beat && w_last) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_b_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (r_state)
            RUN: begin
                busy = 1'b1;
`ifndef GATE_CHAIN_CONST_B_EN
                w_b_ready = 1'b1;
`endif
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Result is formed on the last beat so it is already final in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stage  <= '0;
            r_x_vec  <= '0;
            r_acc    <= 1'b0;
            r_result <= 1'b0;
        end else if (w_start_acc) begin
            r_stage  <= CNT_W'(1);
            r_x_vec  <= {{(N_STAGES-1){1'b0}}, w_x0};
            r_acc    <= w_x0;
            r_result <= 1'b0;
        end else if (w_beat) begin
            r_x_vec[r_stage] <= w_x;
            r_acc            <= r_acc | w_x;
            if (w_last)
                r_result <= ~(r_acc | w_x);
            else
                r_stage <= r_stage + 1'b1;
        end
    end

    assign b_ready     = w_b_ready;
    assign result      = r_result;
    assign x_vec       = r_x_vec;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_gate_chain_seq_eval.sv
// Directed bench for gate_chain_seq_eval: one N=16 and one N=2 instance.
module tb_gate_chain_seq_eval;
    import gate_chain_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sel2 = 1'b0;
    logic [1:0]  a_in = 2'b00;
    logic        b_valid = 1'b0;
    logic        b_in = 1'b0;

    logic        start16, start2, bv16, bv2;
    logic        b_ready16, busy16, done16, result16;
    logic        b_ready2, busy2, done2, result2;
    logic [15:0] x16;
    logic [1:0]  x2;
    state_t      st16, st2;

    logic        b_ready, busy, done, result;
    logic [63:0] x_vec;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    assign start16 = start && !sel2;
    assign start2  = start && sel2;
    assign bv16    = b_valid && !sel2;
    assign bv2     = b_valid && sel2;
    assign b_ready = sel2 ? b_ready2 : b_ready16;
    assign busy    = sel2 ? busy2 : busy16;
    assign done    = sel2 ? done2 : done16;
    assign result  = sel2 ? result2 : result16;
    assign x_vec   = sel2 ? {62'b0, x2} : {48'b0, x16};

    gate_chain_seq_eval #(.A_W(2), .N_STAGES(16)) u_dut16 (
        .clk(clk), .rst(rst), .start(start16), .a_in(a_in),
        .b_valid(bv16), .b_in(b_in), .b_ready(b_ready16), .busy(busy16),
        .done(done16), .result(result16), .x_vec(x16), .o_dbg_state(st16)
    );

    gate_chain_seq_eval #(.A_W(2), .N_STAGES(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .a_in(a_in),
        .b_valid(bv2), .b_in(b_in), .b_ready(b_ready2), .busy(busy2),
        .done(done2), .result(result2), .x_vec(x2), .o_dbg_state(st2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Starts an evaluation at a negedge, feeds beats bvec[1..n-1] whenever
    // b_ready is high (optionally with random idle cycles) and checks the
    // outputs and the start-to-done latency.
    task automatic run_eval(input string tag, input logic [1:0] a, input logic [63:0] bvec,
                            input int n, input bit gappy,
                            input logic [63:0] exp_x, input logic exp_r);
        int lat;
        int idx;
        int gaps;
        int budget;
        bit saw_ready;
        lat = 1;
        idx = 1;
        gaps = 0;
        budget = 0;
        saw_ready = 1'b0;
        a_in = a;
        b_in = bvec[1];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!done && budget < 500) begin
            if (b_ready) saw_ready = 1'b1;
            if (b_ready && idx < n) begin
                if (gappy && $urandom_range(0, 1) == 1) begin
                    b_valid = 1'b0;
                    gaps++;
                end else begin
                    b_valid = 1'b1;
                    b_in = bvec[idx];
                    idx++;
                end
            end else begin
                b_valid = 1'b0;
            end
            @(negedge clk);
            lat++;
            budget++;
        end
        b_valid = 1'b0;
        check({tag, "_done_seen"}, 64'(done), 64'd1);
        check({tag, "_latency"}, 64'(lat), 64'(n + gaps));
        check({tag, "_x_vec"}, x_vec, exp_x);
        check({tag, "_result"}, 64'(result), 64'(exp_r));
`ifdef GATE_CHAIN_CONST_B_EN
        check({tag, "_no_ready"}, 64'(saw_ready), 64'd0);
`endif
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
        check({tag, "_held"}, {x_vec[62:0], result}, {exp_x[62:0], exp_r});
    endtask

    initial begin
        int dones;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy16), 64'd0);
        check("rst_ready", 64'(b_ready16), 64'd0);
        check("rst_done", 64'(done16), 64'd0);
        check("rst_result_x", {47'b0, result16, x16}, 64'd0);
        check("rst_state", 64'(st16), 64'(IDLE));
        rst = 1'b0;
        @(negedge clk);

`ifdef GATE_CHAIN_CONST_B_EN
        run_eval("const_b0", 2'b11, 64'h0, 16, 1'b0, 64'h6666, 1'b0);
`else
        // B beats offered in IDLE are not taken.
        b_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_ready", 64'(b_ready), 64'd0);
        end
        b_valid = 1'b0;

        run_eval("b_zero", 2'b11, 64'h0, 16, 1'b0, 64'h6666, 1'b0);
        run_eval("b_one", 2'b11, 64'hFFFF, 16, 1'b0, 64'h4CCC, 1'b0);
        run_eval("b_alt", 2'b11, 64'hAAAA, 16, 1'b0, 64'h0000, 1'b1);
        run_eval("b_alt_gap", 2'b11, 64'hAAAA, 16, 1'b1, 64'h0000, 1'b1);

        // N=2: start pulsed while busy and in DONE must not retrigger.
        sel2 = 1'b1;
        @(negedge clk);
        a_in = 2'b11;
        b_in = 1'b1;
        start = 1'b1;
        @(negedge clk);
        check("n2_busy", 64'(busy), 64'd1);
        check("n2_ready", 64'(b_ready), 64'd1);
        b_valid = 1'b1;
        dones = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done) dones++;
            b_valid = 1'b0;
            if (k == 1) start = 1'b0;
        end
        check("n2_single_done", 64'(dones), 64'd1);
        check("n2_result", 64'(result), 64'd1);
        check("n2_x_vec", x_vec, 64'h0);
        run_eval("n2_a11", 2'b11, 64'h2, 2, 1'b0, 64'h0, 1'b1);
        run_eval("n2_a01", 2'b01, 64'h2, 2, 1'b0, 64'h1, 1'b0);
        sel2 = 1'b0;
        @(negedge clk);

        // Reset after five accepted beats aborts without a done pulse.
        a_in = 2'b11;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        b_valid = 1'b1;
        b_in = 1'b0;
        repeat (5) @(negedge clk);
        b_valid = 1'b0;
        check("abort_pre_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_ready", 64'(b_ready), 64'd0);
        check("abort_x_res", {47'b0, result, x_vec[15:0]}, 64'd0);
        dones = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("abort_no_done", 64'(dones), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        run_eval("after_abort", 2'b11, 64'h0, 16, 1'b0, 64'h6666, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
